// File: rtl/alu8_issue_ctrl.sv
// alu8_issue_ctrl: issues one instruction at a time to an external
// combinational ALU. Operands come from a 4-entry register file, and the
// result is written back and returned on a valid/ready response channel.
module alu8_issue_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  // instruction channel
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [1:0]       in_rd,
  input  logic [1:0]       in_ra,
  input  logic [1:0]       in_rb,
  input  logic [2:0]       in_shamt,
  // host register-file write port
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  // external ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic [2:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_n,
  input  logic             alu_v,
  // response channel
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [3:0]       res_flags,
  // status
  output logic             err,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [3:0]       r_op;
  logic [1:0]       r_rd;
  logic [1:0]       r_ra;
  logic [1:0]       r_rb;
  logic [2:0]       r_shamt;

  logic [WIDTH-1:0] r_regs [4];
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_res_data;
  logic [3:0]       r_res_flags;
  logic             r_err;

  logic             w_exec;
  logic             w_legal;
  logic             w_accept;
  logic             w_wb;
  logic [3:0]       w_alu_flags;

  assign w_exec      = (r_state == EXEC);
  assign w_legal     = (r_op <= 4'hC);
  assign w_accept    = in_valid && in_ready;
  assign w_wb        = w_exec && w_legal;
  assign w_alu_flags = {alu_z, alu_c, alu_n, alu_v};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (in_valid)  w_state_nxt = EXEC;
      EXEC: w_state_nxt = w_legal ? RESP : IDLE;
      RESP: if (res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Instruction register, captured on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_rd    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_shamt <= '0;
    end else if (w_accept) begin
      r_op    <= in_op;
      r_rd    <= in_rd;
      r_ra    <= in_ra;
      r_rb    <= in_rb;
      r_shamt <= in_shamt;
    end
  end

  // Register file: the EXEC writeback is assigned last so it wins a same-index collision
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '{default: '0};
    end else begin
      if (wr_en) r_regs[wr_addr] <= wr_data;
      if (w_wb)  r_regs[r_rd]    <= alu_y;
    end
  end

  // Flags, response payload and illegal-opcode pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags     <= '0;
      r_res_data  <= '0;
      r_res_flags <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_exec && !w_legal;
      if (w_wb) begin
        r_flags     <= w_alu_flags;
        r_res_flags <= w_alu_flags;
        r_res_data  <= alu_y;
      end
    end
  end

  // ALU drive, forced to zero outside EXEC
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    alu_shamt = '0;
    if (w_exec) begin
      alu_a     = r_regs[r_ra];
      alu_b     = r_regs[r_rb];
      alu_op    = r_op;
      alu_shamt = r_shamt;
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign res_valid = (r_state == RESP);
  assign res_data  = r_res_data;
  assign res_flags = r_res_flags;
  assign err       = r_err;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu8_issue_ctrl.sv
// Directed testbench for alu8_issue_ctrl with a small stand-in ALU model.
module tb_alu8_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_rd, in_ra, in_rb;
  logic [2:0] in_shamt;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic [2:0] alu_shamt;
  logic [7:0] alu_y;
  logic       alu_z, alu_c, alu_n, alu_v;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_flags;
  logic       err;
  logic [3:0] flags;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu8_issue_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_shamt(in_shamt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_y(alu_y), .alu_z(alu_z), .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .err(err), .flags(flags)
  );

  // Stand-in ALU: add, sub (C = no borrow), pass-A, pass-B; other codes do AND
  always_comb begin
    logic [8:0] sum;
    sum   = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      4'h0: begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y = sum[7:0];
        alu_c = sum[8];
        alu_v = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
      end
      4'h1: begin
        alu_y = alu_a - alu_b;
        alu_c = (alu_a >= alu_b);
        alu_v = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
      end
      4'hB:    alu_y = alu_a;
      4'hC:    alu_y = alu_b;
      default: alu_y = alu_a & alu_b;
    endcase
    alu_z = (alu_y == 8'h00);
    alu_n = alu_y[7];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Presents the instruction for one accept edge; returns in the EXEC cycle
  task automatic issue(input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [1:0] rb);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_shamt = 3'd3;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // Full pass-through read of a register (op 0xB, rd = ra) checking the result
  task automatic read_reg(input string tag, input logic [1:0] r, input logic [7:0] exp);
    issue(4'hB, r, r, r);
    tick();
    check(tag, res_data, exp);
    consume();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0;
    in_shamt = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; res_ready = 1'b0;

    // Reset
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_err", err, 0);
    check("rst_flags", flags, 0);
    check("rst_res_data", res_data, 0);
    check("rst_alu_a", alu_a, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Add with overflow: 7F + 01
    host_wr(2'd0, 8'h7F);
    host_wr(2'd1, 8'h01);
    issue(4'h0, 2'd2, 2'd0, 2'd1);
    check("add_exec_alu_a", alu_a, 8'h7F);
    check("add_exec_alu_b", alu_b, 8'h01);
    check("add_exec_shamt", alu_shamt, 3'd3);
    check("add_exec_in_ready", in_ready, 0);
    check("add_exec_res_valid", res_valid, 0);
    tick();
    check("add_res_valid", res_valid, 1);
    check("add_res_data", res_data, 8'h80);
    check("add_res_flags", res_flags, 4'b0011);
    check("add_flags", flags, 4'b0011);
    check("add_resp_alu_a", alu_a, 0);
    consume();
    check("add_back_idle", in_ready, 1);
    check("add_back_res_valid", res_valid, 0);
    read_reg("add_r2", 2'd2, 8'h80);

    // Subtract to zero, then pass-through of the zero result
    host_wr(2'd0, 8'h05);
    host_wr(2'd1, 8'h05);
    issue(4'h1, 2'd3, 2'd0, 2'd1);
    tick();
    check("sub_res_data", res_data, 8'h00);
    check("sub_res_flags", res_flags, 4'b1100);
    consume();
    issue(4'hB, 2'd3, 2'd3, 2'd0);
    tick();
    check("passb_res_data", res_data, 8'h00);
    check("passb_res_flags", res_flags, 4'b1000);
    consume();

    // Illegal opcode: err pulse, no response, r0 and flags untouched
    host_wr(2'd0, 8'h7F);
    issue(4'hE, 2'd0, 2'd0, 2'd1);
    tick();
    check("ill_err", err, 1);
    check("ill_res_valid", res_valid, 0);
    check("ill_in_ready", in_ready, 1);
    check("ill_flags", flags, 4'b1000);
    tick();
    check("ill_err_clear", err, 0);
    check("ill_res_valid_later", res_valid, 0);
    read_reg("ill_r0", 2'd0, 8'h7F);

    // Backpressure: 7F + 05 = 84 held while res_ready is low
    host_wr(2'd1, 8'h05);
    issue(4'h0, 2'd3, 2'd0, 2'd1);
    tick();
    in_valid = 1'b1; in_op = 4'h1;
    for (int i = 0; i < 5; i++) begin
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, 8'h84);
      check("bp_res_flags", res_flags, 4'b0011);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    consume();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_res_valid", res_valid, 0);

    // Write collision on the destination index: writeback wins
    host_wr(2'd0, 8'h7F);
    host_wr(2'd1, 8'h01);
    host_wr(2'd2, 8'h00);
    issue(4'h0, 2'd2, 2'd0, 2'd1);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    check("col_same_res", res_data, 8'h80);
    consume();
    read_reg("col_same_r2", 2'd2, 8'h80);

    // Collision on a different index: both writes land
    host_wr(2'd2, 8'h00);
    issue(4'h0, 2'd2, 2'd0, 2'd1);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    check("col_diff_res", res_data, 8'h80);
    consume();
    read_reg("col_diff_r1", 2'd1, 8'h55);
    read_reg("col_diff_r2", 2'd2, 8'h80);

    // Reset during EXEC discards the instruction and clears state
    host_wr(2'd3, 8'h33);
    issue(4'h0, 2'd2, 2'd0, 2'd1);
    rst = 1'b1;
    tick();
    check("mrst_res_valid", res_valid, 0);
    check("mrst_flags", flags, 0);
    check("mrst_res_data", res_data, 0);
    check("mrst_alu_a", alu_a, 0);
    rst = 1'b0;
    #1;
    check("mrst_in_ready", in_ready, 1);
    tick();
    check("mrst_no_resp", res_valid, 0);
    read_reg("mrst_r0", 2'd0, 8'h00);
    read_reg("mrst_r1", 2'd1, 8'h00);
    read_reg("mrst_r3", 2'd3, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu8_issue_ctrl.md
# alu8_issue_ctrl

Sequential issue controller that acts as the initiator for the team's combinational 8-bit ALU (opcodes 0x0–0xC, flags Z/C/N/V). It accepts one instruction at a time over a valid/ready handshake and reads two operands from a 4-entry internal register file. It drives the external ALU ports for one cycle, then writes the result back and latches the flags. The result and flags are presented on a valid/ready response channel.

## Interface
- WIDTH, 8, datapath width; must match the attached ALU.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction valid.
- in_ready  output  1  controller can accept an instruction (IDLE only).
- in_op  input  4  ALU opcode.
- in_rd, in_ra, in_rb  input  2 each  destination and source register indices.
- in_shamt  input  3  shift amount, forwarded to the ALU.
- wr_en  input  1  host register-file write.
- wr_addr  input  2  host write index.
- wr_data  input  WIDTH  host write data.
- alu_a, alu_b  output  WIDTH  operands to the ALU.
- alu_op  output  4  opcode to the ALU.
- alu_shamt  output  3  shift amount to the ALU.
- alu_y  input  WIDTH  ALU result (combinational from alu_*).
- alu_z, alu_c, alu_n, alu_v  input  1 each  ALU flags.
- res_valid  output  1  response valid.
- res_ready  input  1  response consumer ready.
- res_data  output  WIDTH  result written back.
- res_flags  output  4  {Z,C,N,V} of that operation.
- err  output  1  one-cycle pulse: illegal opcode (0xD–0xF) accepted.
- flags  output  4  architectural {Z,C,N,V}, updated only by legal ops.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: in_ready=1. On in_valid, capture op/rd/ra/rb/shamt into an instruction register and go to EXEC.
- EXEC: alu_a=regs[ra], alu_b=regs[rb], alu_op=op, alu_shamt=shamt. Operands are read in this cycle, so a host write completed at or before the accept edge is visible.
- At the end of EXEC, legal op (0x0–0xC):
  - regs[rd] <= alu_y.
  - flags, res_flags <= {alu_z,alu_c,alu_n,alu_v}.
  - res_data <= alu_y.
  - Go to RESP.
- At the end of EXEC, illegal op (0xD–0xF):
  - No writeback; flags unchanged.
  - err=1 for exactly the following cycle.
  - Return to IDLE; no response is issued.
- RESP: res_valid=1, res_data/res_flags held stable until res_ready=1. At the edge where res_valid && res_ready, return to IDLE.
- Outside EXEC, alu_a/alu_b/alu_op/alu_shamt drive 0.
- Host port: wr_en writes regs[wr_addr] in any state. If it coincides with the EXEC writeback to the same index, the writeback wins. Different indices: both writes take effect.
- Ops 0xB/0xC pass regs[ra]/regs[rb] through the ALU unchanged; they still update flags.

## Timing
- Reset values:
  - state=IDLE, regs all 0, flags=0.
  - res_valid=0, res_data=0, res_flags=0, err=0.
  - alu_* outputs 0.
  - in_ready=0 during the reset cycle, 1 in the first cycle after reset.
- Instruction accepted at edge T. EXEC occupies cycle T..T+1. res_valid is 1 starting after edge T+1, so minimum accept-to-response latency is 2 edges.
- The written register is readable by the next instruction, whose EXEC is ≥2 cycles later; no bypass is needed.
- Throughput: at most one instruction every 3 cycles with res_ready held high.
- in_ready is 0 in EXEC and RESP; in_valid is ignored there.
- rst asserted in any state returns to IDLE next edge and discards the in-flight instruction and any pending response. Registers and flags clear.

## Test plan
- Add with overflow: load r0=0x7F, r1=0x01, issue op=0x0 rd=2 ra=0 rb=1 -> res_data=0x80, res_flags={Z0,C0,N1,V1}, r2=0x80, res_valid 2 edges after accept.
- Subtract to zero: r0=0x05, r1=0x05, op=0x1 rd=3 -> res_data=0x00, res_flags={Z1,C1,N0,V0}. A follow-up op=0xB ra=3 returns 0x00 with Z=1.
- Illegal opcode: op=0xE rd=0 with r0=0x7F -> err pulses 1 cycle, no res_valid, r0 stays 0x7F, flags unchanged from the previous op.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data/res_flags stable, in_ready=0. Raising res_ready returns to IDLE on the next edge.
- Write collision: host wr_en to r2=0x55 in the same cycle as the EXEC writeback of 0x80 to r2 -> r2=0x80. The same test with host write to r1 -> r1=0x55 and r2=0x80.
- Reset mid-operation: assert rst during EXEC -> next cycle state IDLE, res_valid=0, all regs 0, flags 0; the instruction produces no response.
